// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store controller placed in front of a word-addressed data memory. The
// memory reads combinationally and writes synchronously.
// Byte-addressed requests from the execute stage arrive on a valid/ready
// channel. Each request is mapped onto the memory word port. Byte and half
// stores use a read-modify-write sequence. Load data comes back sign- or
// zero-extended on a valid/ready response channel, or the response reports an
// error instead.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. The producer keeps valid and its
// payload stable until that edge. req_ready is high only in IDLE. resp_valid is
// high only in RESP, and the response payload is stable for the whole RESP
// state.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_size,          store flag, size (00 B, 01 H, 10 W, 11 illegal),
//   req_unsigned               zero-extend flag for loads
//   req_addr, req_wdata        byte address, right-aligned store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_err       extended load data (0 for stores/errors), error
//   mem_address, mem_data_in,  memory word port: address, write data,
//   mem_read_en, mem_write_en  read enable, write enable
//   mem_data_out               memory read data (combinational)
//
// Optional feature, macro LSU_ACCESS_CNT_EN: adds the load_cnt, store_cnt and
// err_cnt outputs. Each counter counts completed responses of its kind.
//
// The FSM state is in state_q, which has type state_t.
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int A_BITS = 10,
  parameter int D_BITS = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [D_BITS-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [D_BITS-1:0] resp_rdata,
  output logic              resp_err,
  output logic [A_BITS-1:0] mem_address,
  output logic [D_BITS-1:0] mem_data_in,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [D_BITS-1:0] mem_data_out
`ifdef LSU_ACCESS_CNT_EN
  ,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
  output logic [31:0]       err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t              state_q, state_d;
  // Only the in-range part of the address is kept. An out-of-range address is
  // rejected at accept time.
  logic [A_BITS+1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic [D_BITS-1:0]   wdata_q, wdata_d;
  logic [D_BITS-1:0]   merge_q, merge_d;
  logic [D_BITS-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                accept;
  logic                req_err;
  logic [4:0]          byte_sh;
  logic [4:0]          half_sh;
  logic [D_BITS-1:0]   rd_shift;
  logic [D_BITS-1:0]   load_ext;
  logic [D_BITS-1:0]   merged;
  logic [D_BITS-1:0]   lane_mask;
  logic [D_BITS-1:0]   lane_data;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign accept = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                         req_err = 1'b1;
    if ((req_size == SZ_H) && req_addr[0])         req_err = 1'b1;
    if ((req_size == SZ_W) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if ((req_addr >> (A_BITS + 2)) != '0)          req_err = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Datapath: lane select for loads, lane merge for sub-word stores
  // ---------------------------------------------------------------------------
  assign byte_sh = {addr_q[1:0], 3'b000};
  assign half_sh = {addr_q[1], 4'b0000};

  // A word load is aligned, so its shift is always 0.
  assign rd_shift = mem_data_out >> byte_sh;

  always_comb begin
    load_ext = rd_shift;
    case (size_q)
      SZ_B: load_ext = uns_q ? {{(D_BITS-8){1'b0}}, rd_shift[7:0]}
                             : {{(D_BITS-8){rd_shift[7]}}, rd_shift[7:0]};
      SZ_H: load_ext = uns_q ? {{(D_BITS-16){1'b0}}, rd_shift[15:0]}
                             : {{(D_BITS-16){rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    if (size_q == SZ_H) begin
      lane_mask = {{(D_BITS-16){1'b0}}, 16'hFFFF} << half_sh;
      lane_data = {{(D_BITS-16){1'b0}}, wdata_q[15:0]} << half_sh;
    end else begin
      lane_mask = {{(D_BITS-8){1'b0}}, 8'hFF} << byte_sh;
      lane_data = {{(D_BITS-8){1'b0}}, wdata_q[7:0]} << byte_sh;
    end
    merged = (mem_data_out & ~lane_mask) | lane_data;
  end

  // ---------------------------------------------------------------------------
  // State register and latched request fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and next datapath values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr[A_BITS+1:0];
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          merge_d = '0;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)              state_d = S_RESP;
          else if (!req_we)         state_d = S_LOAD;
          else if (req_size == SZ_W) state_d = S_WRITE;
          else                      state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = merged;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // While reset is held, req_ready stays low even though the state is IDLE.
    req_ready    = (state_q == S_IDLE) && rst_n;
    resp_valid   = (state_q == S_RESP);
    resp_rdata   = rdata_q;
    resp_err     = err_q;
    mem_read_en  = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    mem_write_en = (state_q == S_WRITE);
    mem_address  = '0;
    mem_data_in  = '0;
    if ((state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_WRITE))
      mem_address = addr_q[A_BITS+1:2];
    if (state_q == S_WRITE)
      mem_data_in = (size_q == SZ_W) ? wdata_q : merge_q;
  end

`ifdef LSU_ACCESS_CNT_EN
  // ---------------------------------------------------------------------------
  // Access counters, bumped when a response completes; wrap naturally
  // ---------------------------------------------------------------------------
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (resp_valid && resp_ready) begin
      if (err_q)     err_cnt_d   = err_cnt_q + 32'd1;
      else if (we_q) store_cnt_d = store_cnt_q + 32'd1;
      else           load_cnt_d  = load_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
